// File: rtl/branch_unit_pkg.sv
// rtl/branch_unit_pkg.sv - shared widths, branch opcode encodings and FSM states for branch_unit
package branch_unit_pkg;

  localparam int DWORD_W  = 64;
  localparam int ADDR_W_D = 32;
  localparam int TAG_W_D  = 4;
  localparam int OP_W_D   = 6;

  typedef logic [DWORD_W-1:0]  dword_t;
  typedef logic [ADDR_W_D-1:0] addr_t;
  typedef logic [TAG_W_D-1:0]  regtag_t;
  typedef logic [OP_W_D-1:0]   sinst_t;

  localparam regtag_t UNLOCKED = '0;

  localparam sinst_t OP_BEQ  = 6'h01;
  localparam sinst_t OP_BNE  = 6'h02;
  localparam sinst_t OP_BLT  = 6'h03;
  localparam sinst_t OP_BGE  = 6'h04;
  localparam sinst_t OP_BLTU = 6'h05;
  localparam sinst_t OP_BGEU = 6'h06;
  localparam sinst_t OP_JAL  = 6'h07;
  localparam sinst_t OP_JALR = 6'h08;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_REDIR,
    S_DONE
  } state_t;

endpackage

// File: rtl/branch_alu.sv
// rtl/branch_alu.sv - branch condition comparator, target adder and link value
module branch_alu
  import branch_unit_pkg::*;
#(
  parameter int XLEN   = DWORD_W,
  parameter int ADDR_W = ADDR_W_D,
  parameter int OP_W   = OP_W_D
) (
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] pc,
  input  logic [XLEN-1:0]   offset,
  input  logic [XLEN-1:0]   datax,
  input  logic [XLEN-1:0]   datay,
  output logic              taken,
  output logic              jump,
  output logic [ADDR_W-1:0] target,
  output logic [XLEN-1:0]   link
);

  logic [ADDR_W-1:0] jalr_sum;
  logic [ADDR_W-1:0] pc_plus4;

  assign jalr_sum = ADDR_W'(datax + offset);
  assign pc_plus4 = pc + ADDR_W'(4);
  assign link     = {{(XLEN-ADDR_W){1'b0}}, pc_plus4};

  always_comb begin
    taken = 1'b0;
    jump  = 1'b0;
    case (op)
      OP_W'(OP_BEQ):  taken = (datax == datay);
      OP_W'(OP_BNE):  taken = (datax != datay);
      OP_W'(OP_BLT):  taken = ($signed(datax) <  $signed(datay));
      OP_W'(OP_BGE):  taken = ($signed(datax) >= $signed(datay));
      OP_W'(OP_BLTU): taken = (datax <  datay);
      OP_W'(OP_BGEU): taken = (datax >= datay);
      OP_W'(OP_JAL), OP_W'(OP_JALR): begin
        taken = 1'b1;
        jump  = 1'b1;
      end
      default: taken = 1'b0;
    endcase
  end

  // JALR targets a register-relative address with bit0 forced low
  assign target = (op == OP_W'(OP_JALR)) ? (jalr_sum & ~ADDR_W'(1))
                                         : (pc + offset[ADDR_W-1:0]);

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch resolution FSM with link writeback, redirect handshake and taken counter
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int XLEN   = DWORD_W,
  parameter int ADDR_W = ADDR_W_D,
  parameter int TAG_W  = TAG_W_D,
  parameter int OP_W   = OP_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              rs_busy,
  input  logic [OP_W-1:0]   rs_op,
  input  logic [ADDR_W-1:0] rs_pc,
  input  logic [XLEN-1:0]   rs_offset,
  input  logic [TAG_W-1:0]  rs_tagx,
  input  logic [TAG_W-1:0]  rs_tagy,
  input  logic [XLEN-1:0]   rs_datax,
  input  logic [XLEN-1:0]   rs_datay,
  input  logic [TAG_W-1:0]  rs_tagw,
  output logic              rs_ack,
  output logic              wb_valid,
  input  logic              wb_grant,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [XLEN-1:0]   wb_data,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [ADDR_W-1:0] redir_pc,
  output logic              misalign,
  output logic [31:0]       taken_cnt
);

  state_t state, state_nxt;

  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] pc_q;
  logic [XLEN-1:0]   offset_q, datax_q, datay_q;
  logic [TAG_W-1:0]  tagw_q;
  logic              mis_q;

  logic              taken, jump;
  logic [ADDR_W-1:0] target;
  logic [XLEN-1:0]   link;
  logic              exec_fire;

  branch_alu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .OP_W(OP_W)) u_alu (
    .op     (op_q),
    .pc     (pc_q),
    .offset (offset_q),
    .datax  (datax_q),
    .datay  (datay_q),
    .taken  (taken),
    .jump   (jump),
    .target (target),
    .link   (link)
  );

  // flush kills regardless of stall; every other move waits for rdy
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else if (rdy) begin
      case (state)
        S_IDLE:  if (rs_busy && rs_tagx == TAG_W'(UNLOCKED) && rs_tagy == TAG_W'(UNLOCKED))
                   state_nxt = S_EXEC;
        S_EXEC:  if (jump)                       state_nxt = S_WB;
                 else if (taken && !target[1])   state_nxt = S_REDIR;
                 else                            state_nxt = S_DONE;
        S_WB:    if (wb_grant)    state_nxt = mis_q ? S_DONE : S_REDIR;
        S_REDIR: if (redir_ready) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign exec_fire = (state == S_EXEC) && rdy && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      pc_q      <= '0;
      offset_q  <= '0;
      datax_q   <= '0;
      datay_q   <= '0;
      tagw_q    <= '0;
      mis_q     <= 1'b0;
      wb_tag    <= '0;
      wb_data   <= '0;
      redir_pc  <= '0;
      taken_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_EXEC) begin
        op_q     <= rs_op;
        pc_q     <= rs_pc;
        offset_q <= rs_offset;
        datax_q  <= rs_datax;
        datay_q  <= rs_datay;
        tagw_q   <= rs_tagw;
      end
      // results are frozen on EXEC exit so the handshakes see stable values
      if (exec_fire) begin
        wb_tag   <= tagw_q;
        wb_data  <= link;
        redir_pc <= target;
        mis_q    <= taken & target[1];
      end
      if (state == S_REDIR && state_nxt == S_DONE)
        taken_cnt <= taken_cnt + 32'd1;
    end
  end

  assign rs_ack      = (state == S_DONE);
  assign misalign    = (state == S_DONE) && mis_q;
  assign wb_valid    = (state == S_WB);
  assign redir_valid = (state == S_REDIR);

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed and randomized self-checking bench for branch_unit
module tb_branch_unit;
  import branch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        rs_busy = 1'b0;
  logic [5:0]  rs_op = '0;
  logic [31:0] rs_pc = '0;
  logic [63:0] rs_offset = '0;
  logic [3:0]  rs_tagx = '0;
  logic [3:0]  rs_tagy = '0;
  logic [63:0] rs_datax = '0;
  logic [63:0] rs_datay = '0;
  logic [3:0]  rs_tagw = '0;
  logic        rs_ack;
  logic        wb_valid;
  logic        wb_grant = 1'b0;
  logic [3:0]  wb_tag;
  logic [63:0] wb_data;
  logic        redir_valid;
  logic        redir_ready = 1'b0;
  logic [31:0] redir_pc;
  logic        misalign;
  logic [31:0] taken_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .rs_busy(rs_busy),
    .rs_op(rs_op), .rs_pc(rs_pc), .rs_offset(rs_offset), .rs_tagx(rs_tagx),
    .rs_tagy(rs_tagy), .rs_datax(rs_datax), .rs_datay(rs_datay), .rs_tagw(rs_tagw),
    .rs_ack(rs_ack), .wb_valid(wb_valid), .wb_grant(wb_grant), .wb_tag(wb_tag),
    .wb_data(wb_data), .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_pc(redir_pc), .misalign(misalign), .taken_cnt(taken_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_taken(input logic [5:0] op, input logic [63:0] x, input logic [63:0] y);
    longint sx, sy;
    sx = x;
    sy = y;
    case (op)
      OP_BEQ:  return x == y;
      OP_BNE:  return x != y;
      OP_BLT:  return sx < sy;
      OP_BGE:  return sx >= sy;
      OP_BLTU: return x < y;
      OP_BGEU: return x >= y;
      OP_JAL, OP_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input logic [5:0] op, input logic [31:0] pc,
                                               input logic [63:0] off, input logic [63:0] x);
    logic [63:0] s;
    if (op == OP_JALR) begin
      s = x + off;
      return s[31:0] & 32'hFFFF_FFFE;
    end
    s = {32'd0, pc} + off;
    return s[31:0];
  endfunction

  task automatic wait_for(input bit want_wb, input string tag);
    int n = 0;
    while (!(want_wb ? wb_valid : redir_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, want_wb ? wb_valid : redir_valid, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, rs_ack, 0);
    chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_rdv"}, redir_valid, 0);
    chk({tag, "_mis"}, misalign, 0);
    chk({tag, "_wbtag"}, wb_tag, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_rpc"}, redir_pc, 0);
    chk({tag, "_cnt"}, taken_cnt, 0);
  endtask

  // Issue one branch, play the handshakes with the given delays and compare with the model.
  task automatic run_branch(input logic [5:0] op, input logic [31:0] pc, input logic [63:0] off,
                            input logic [63:0] x, input logic [63:0] y, input logic [3:0] tw,
                            input int gd, input int rd, input int lock, input string tag);
    bit exp_t, jmp, mis, exp_redir, early, saw_wb, saw_redir, got_ack, unstable;
    logic [31:0] tgt, cnt0, rpc0, link;
    logic [63:0] wbd0;
    logic [3:0]  wbt0;
    int exp_lat, cyc, ack_cyc, wbc, rc, mis_n;
    exp_t = model_taken(op, x, y);
    tgt = model_target(op, pc, off, x);
    link = pc + 32'd4;
    jmp = (op == OP_JAL) || (op == OP_JALR);
    mis = exp_t && tgt[1];
    exp_redir = exp_t && !mis;
    exp_lat = 2 + (jmp ? gd + 1 : 0) + (exp_redir ? rd + 1 : 0);
    cnt0 = taken_cnt;
    early = 0; saw_wb = 0; saw_redir = 0; got_ack = 0; unstable = 0;
    wbc = 0; rc = 0; mis_n = 0; ack_cyc = -1;
    wbd0 = '0; wbt0 = '0; rpc0 = '0;
    rs_op = op; rs_pc = pc; rs_offset = off; rs_datax = x; rs_datay = y; rs_tagw = tw;
    rs_tagx = '0; rs_tagy = (lock > 0) ? 4'd7 : 4'd0; rs_busy = 1'b1;
    for (int i = 0; i < lock; i++) begin
      @(negedge clk);
      if (rs_ack || wb_valid || redir_valid) early = 1;
    end
    if (lock > 0) chk({tag, "_locked"}, early, 0);
    rs_tagy = '0;
    @(negedge clk);
    rs_busy = 1'b0;
    rs_datax = {$urandom, $urandom};
    cyc = 1;
    while (!got_ack && cyc < 60) begin
      if (wb_valid) begin
        if (!saw_wb) begin wbd0 = wb_data; wbt0 = wb_tag; end
        else if (wb_data !== wbd0 || wb_tag !== wbt0) unstable = 1;
        saw_wb = 1;
        wbc++;
      end
      if (redir_valid) begin
        if (!saw_redir) rpc0 = redir_pc;
        else if (redir_pc !== rpc0) unstable = 1;
        saw_redir = 1;
        rc++;
      end
      if (misalign) mis_n++;
      if (rs_ack) begin got_ack = 1; ack_cyc = cyc; end
      wb_grant = wb_valid && (wbc > gd);
      redir_ready = redir_valid && (rc > rd);
      @(negedge clk);
      cyc++;
    end
    wb_grant = 1'b0;
    redir_ready = 1'b0;
    chk({tag, "_ack_lat"}, ack_cyc, exp_lat);
    chk({tag, "_ack_pulse"}, rs_ack, 0);
    chk({tag, "_wb_seen"}, saw_wb, jmp);
    if (saw_wb) begin
      chk({tag, "_wb_data"}, wbd0, {32'd0, link});
      chk({tag, "_wb_tag"}, wbt0, tw);
    end
    chk({tag, "_redir_seen"}, saw_redir, exp_redir);
    if (saw_redir) chk({tag, "_redir_pc"}, rpc0, tgt);
    chk({tag, "_stable"}, unstable, 0);
    chk({tag, "_misalign"}, mis_n, mis);
    chk({tag, "_cnt"}, taken_cnt, cnt0 + exp_redir);
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [31:0] cnt0;
    bit seen_ack;
    ops = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR, 6'h3F};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    run_branch(OP_BEQ, 32'h100, 64'h20, 64'd5, 64'd5, 4'h3, 0, 0, 0, "beq_taken");
    chk("beq_cnt_one", taken_cnt, 1);
    run_branch(OP_BLT, 32'h200, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h1, 0, 0, 0, "blt_neg");
    run_branch(OP_BLTU, 32'h200, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h1, 0, 0, 0, "bltu_neg");
    run_branch(OP_JALR, 32'h300, 64'h0, 64'h2001, 64'd0, 4'h9, 3, 0, 0, "jalr_delay");
    run_branch(OP_BNE, 32'h400, 64'h10, 64'd1, 64'd2, 4'h2, 0, 1, 4, "tag_lock");
    run_branch(OP_BEQ, 32'h100, 64'h2, 64'd7, 64'd7, 4'h2, 0, 0, 0, "misalign");
    run_branch(OP_JAL, 32'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0, 4'hA, 0, 2, 0, "jal_back");
    run_branch(OP_JAL, 32'h1000, 64'h6, 64'd0, 64'd0, 4'hB, 1, 0, 0, "jal_mis");
    run_branch(OP_BGE, 32'h500, 64'h8, 64'd9, 64'd9, 4'h4, 0, 0, 0, "bge_eq");
    run_branch(OP_BGEU, 32'h500, 64'h8, 64'd3, 64'd9, 4'h4, 0, 0, 0, "bgeu_lt");
    run_branch(6'h3F, 32'h600, 64'h8, 64'd4, 64'd4, 4'h5, 0, 0, 0, "unknown_op");
    run_branch(OP_JAL, 32'hFFFF_FFFC, 64'h8, 64'd0, 64'd0, 4'h6, 0, 0, 0, "link_wrap");

    for (int i = 0; i < 40; i++) begin
      logic [63:0] rx, ry;
      rx = {$urandom, $urandom};
      ry = ($urandom_range(0, 3) == 0) ? rx : {$urandom, $urandom};
      run_branch(ops[$urandom_range(0, 8)], $urandom, {$urandom, $urandom}, rx, ry,
                 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), 0, "rand");
    end

    // stall while the redirect is offered
    cnt0 = taken_cnt;
    rs_op = OP_BEQ; rs_pc = 32'h700; rs_offset = 64'h40; rs_datax = 64'd1; rs_datay = 64'd1;
    rs_busy = 1'b1;
    @(negedge clk);
    rs_busy = 1'b0;
    wait_for(0, "stall_wait");
    rdy = 1'b0; redir_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_hold_rdv", redir_valid, 1);
    chk("stall_hold_cnt", taken_cnt, cnt0);
    chk("stall_no_ack", rs_ack, 0);
    rdy = 1'b1;
    @(negedge clk);
    redir_ready = 1'b0;
    chk("stall_ack", rs_ack, 1);
    chk("stall_cnt", taken_cnt, cnt0 + 32'd1);
    @(negedge clk);
    chk("stall_ack_pulse", rs_ack, 0);

    // flush while redirect is stuck waiting, with ready arriving in the same cycle
    cnt0 = taken_cnt;
    rs_busy = 1'b1;
    @(negedge clk);
    rs_busy = 1'b0;
    wait_for(0, "flush_wait");
    @(negedge clk);
    chk("flush_pre_rdv", redir_valid, 1);
    flush = 1'b1; redir_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; redir_ready = 1'b0;
    chk("flush_rdv", redir_valid, 0);
    chk("flush_ack", rs_ack, 0);
    chk("flush_cnt", taken_cnt, cnt0);
    @(negedge clk);
    chk("flush_no_late_ack", rs_ack, 0);

    // asynchronous reset while the link result is offered
    rs_op = OP_JAL; rs_pc = 32'h800; rs_offset = 64'h100; rs_tagw = 4'hC; rs_busy = 1'b1;
    @(negedge clk);
    rs_busy = 1'b0;
    wait_for(1, "rstwb_wait");
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid_wb");
    @(negedge clk);
    rst = 1'b1;
    seen_ack = 0;
    repeat (5) begin
      @(negedge clk);
      if (rs_ack || wb_valid || redir_valid) seen_ack = 1;
    end
    chk("rst_no_ack", seen_ack, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
